// File: rtl/axis_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_tx_arbiter
// Purpose  : Packet-level round-robin arbiter that shares one AXI-stream byte
//            channel (feeding the RS232 transmitter) between NUM sources.
//            A granted source owns the channel until its ilast byte or until
//            the stall timeout abandons the packet. An optional header byte
//            {4'hA, 1'b0, grant} identifies the source on the serial link.
// Ports    : clock, reset            - clock, synchronous active-high reset
//            idata/ivalid/ilast      - per-source byte lanes (source k uses
//                                      idata[8k+7:8k])
//            iready                  - per-source ready (combinational)
//            odata/ovalid/oready     - registered output byte channel
//            grant                   - current or most recent grantee
//            busy                    - high while not idle
//            timeout                 - one-cycle pulse when a packet is dropped
// Revision : 1.0 - initial release
// ============================================================================
module axis_tx_arbiter #(
    parameter int NUM     = 4,
    parameter int HEADER  = 1,
    parameter int TIMEOUT = 65535
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [8*NUM-1:0] idata,
    input  logic [NUM-1:0]   ivalid,
    input  logic [NUM-1:0]   ilast,
    output logic [NUM-1:0]   iready,
    output logic [7:0]       odata,
    output logic             ovalid,
    input  logic             oready,
    output logic [2:0]       grant,
    output logic             busy,
    output logic             timeout
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HEAD = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;

    // Stall counter just wide enough to hold TIMEOUT.
    localparam int              c_CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CW-1:0] c_TMAX = c_CW'(TIMEOUT);
    localparam logic [c_CW-1:0] c_TLIM = c_CW'(TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [1:0]      r_state;
    logic [2:0]      r_grant;
    logic [7:0]      r_odata;
    logic            r_ovalid;
    logic [c_CW-1:0] r_stall;
    logic            r_timeout;

    logic            w_load_ok;
    logic            w_cur_valid;
    logic            w_cur_last;
    logic [7:0]      w_cur_data;
    logic            w_xfer;
    logic            w_load;
    logic [7:0]      w_load_byte;
    logic            w_any;
    logic            w_hit_hi;
    logic [2:0]      w_sel_hi;
    logic [2:0]      w_sel_lo;
    logic [2:0]      w_sel;

    // The output register can accept a new byte when empty or draining.
    assign w_load_ok = !r_ovalid || oready;

    // Lanes of the current grantee.
    always_comb begin
        w_cur_valid = 1'b0;
        w_cur_last  = 1'b0;
        w_cur_data  = 8'h00;
        for (int k = 0; k < NUM; k++) begin
            if (r_grant == 3'(k)) begin
                w_cur_valid = ivalid[k];
                w_cur_last  = ilast[k];
                w_cur_data  = idata[8*k +: 8];
            end
        end
    end

    // Round-robin pick: the lowest requester above the pointer wins; if there
    // is none, wrap and take the lowest requester at or below the pointer.
    // The descending loop leaves the lowest matching index in each bucket.
    always_comb begin
        w_hit_hi = 1'b0;
        w_sel_hi = 3'd0;
        w_sel_lo = 3'd0;
        for (int k = NUM - 1; k >= 0; k--) begin
            if (ivalid[k]) begin
                if (3'(k) > r_grant) begin
                    w_sel_hi = 3'(k);
                    w_hit_hi = 1'b1;
                end else begin
                    w_sel_lo = 3'(k);
                end
            end
        end
        w_sel = w_hit_hi ? w_sel_hi : w_sel_lo;
    end

    assign w_any       = |ivalid;
    assign w_xfer      = (r_state == c_ST_DATA) && w_cur_valid && w_load_ok;
    assign w_load      = ((r_state == c_ST_HEAD) && w_load_ok) || w_xfer;
    assign w_load_byte = (r_state == c_ST_HEAD) ? {4'hA, 1'b0, r_grant} : w_cur_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_grant   <= 3'(NUM - 1);
            r_odata   <= 8'h00;
            r_ovalid  <= 1'b0;
            r_stall   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;

            if (w_load) begin
                r_odata  <= w_load_byte;
                r_ovalid <= 1'b1;
            end else if (oready) begin
                r_ovalid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_stall <= '0;
                    if (w_any) begin
                        r_grant <= w_sel;
                        r_state <= (HEADER != 0) ? c_ST_HEAD : c_ST_DATA;
                    end
                end
                c_ST_HEAD: begin
                    r_stall <= '0;
                    if (w_load_ok) begin
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    // A transfer always wins over an expiring stall count.
                    if (w_xfer) begin
                        r_stall <= '0;
                        if (w_cur_last) begin
                            r_state <= c_ST_IDLE;
                        end
                    end else if ((TIMEOUT != 0) && (r_stall == c_TLIM)) begin
                        r_state   <= c_ST_IDLE;
                        r_timeout <= 1'b1;
                        r_stall   <= '0;
                    end else if (r_stall != c_TMAX) begin
                        r_stall <= r_stall + c_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Only the grantee sees ready, and only in DATA; never a function of ivalid.
    for (genvar k = 0; k < NUM; k++) begin : g_iready
        assign iready[k] = (r_state == c_ST_DATA) && (r_grant == 3'(k)) && w_load_ok;
    end

    assign odata   = r_odata;
    assign ovalid  = r_ovalid;
    assign grant   = r_grant;
    assign busy    = (r_state != c_ST_IDLE);
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_axis_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_tx_arbiter
// Purpose  : Self-checking bench for axis_tx_arbiter. Instance u_dut uses
//            NUM=4, HEADER=1, TIMEOUT=8; instance u_dut0 uses HEADER=0 with
//            the timeout disabled. Expected output bytes are queued when a
//            packet is offered and compared as the transmitter accepts them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_tx_arbiter;

    logic        clock;
    logic        reset;

    logic [31:0] a_idata;
    logic [3:0]  a_ivalid;
    logic [3:0]  a_ilast;
    logic [3:0]  a_iready;
    logic [7:0]  a_odata;
    logic        a_ovalid;
    logic        a_oready;
    logic [2:0]  a_grant;
    logic        a_busy;
    logic        a_timeout;

    logic [31:0] b_idata;
    logic [3:0]  b_ivalid;
    logic [3:0]  b_ilast;
    logic [3:0]  b_iready;
    logic [7:0]  b_odata;
    logic        b_ovalid;
    logic        b_oready;
    logic [2:0]  b_grant;
    logic        b_busy;
    logic        b_timeout;

    axis_tx_arbiter #(.NUM(4), .HEADER(1), .TIMEOUT(8)) u_dut (
        .clock  (clock),
        .reset  (reset),
        .idata  (a_idata),
        .ivalid (a_ivalid),
        .ilast  (a_ilast),
        .iready (a_iready),
        .odata  (a_odata),
        .ovalid (a_ovalid),
        .oready (a_oready),
        .grant  (a_grant),
        .busy   (a_busy),
        .timeout(a_timeout)
    );

    axis_tx_arbiter #(.NUM(4), .HEADER(0), .TIMEOUT(0)) u_dut0 (
        .clock  (clock),
        .reset  (reset),
        .idata  (b_idata),
        .ivalid (b_ivalid),
        .ilast  (b_ilast),
        .iready (b_iready),
        .odata  (b_odata),
        .ovalid (b_ovalid),
        .oready (b_oready),
        .grant  (b_grant),
        .busy   (b_busy),
        .timeout(b_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks;
    int          errors;
    logic        sb_on;
    logic [7:0]  exp_q[$];
    logic [8:0]  sq[4][$];   // per-source {last, data} still to be offered
    logic [3:0]  a_acc;
    logic        prev_stall;
    logic [7:0]  prev_data;

    typedef struct {
        int         src;
        int         len;
        logic [7:0] base;
        logic [2:0] exp_grant;
    } pkt_t;

    pkt_t        tbl[4];
    logic [7:0]  d;
    logic [7:0]  got[$];
    logic [3:0]  bacc;
    logic [3:0]  pat;
    logic        seen;
    int          first;
    int          pulses;
    int          nacc;
    int          s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input int lim);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || a_busy) && n < lim) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || a_busy) begin
            errors++;
            $display("FAIL drain: outstanding=%0d busy=%0b, required 0 and 0", exp_q.size(), a_busy);
        end
    endtask

    // Source model for u_dut: presents the head of each source queue and
    // retires it after a handshake seen at the preceding falling edge.
    initial begin
        a_idata  = '0;
        a_ivalid = '0;
        a_ilast  = '0;
        forever begin
            @(posedge clock);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (a_acc[k] && sq[k].size() > 0) void'(sq[k].pop_front());
                if (sq[k].size() > 0) begin
                    a_ivalid[k]       = 1'b1;
                    a_idata[8*k +: 8] = sq[k][0][7:0];
                    a_ilast[k]        = sq[k][0][8];
                end else begin
                    a_ivalid[k] = 1'b0;
                    a_ilast[k]  = 1'b0;
                end
            end
        end
    end

    // Output scoreboard and stall-stability monitor for u_dut.
    initial begin
        a_acc      = '0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clock);
            a_acc = a_ivalid & a_iready;
            if (sb_on) begin
                if (a_ovalid && a_oready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra: got 0x%0h, required no byte", a_odata);
                    end else begin
                        d = exp_q.pop_front();
                        if (a_odata !== d) begin
                            errors++;
                            $display("FAIL sb_byte: got 0x%0h, required 0x%0h", a_odata, d);
                        end
                    end
                end
                if (prev_stall) begin
                    checks++;
                    if (!a_ovalid || a_odata !== prev_data) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%0b 0x%0h, required v=1 0x%0h", a_ovalid, a_odata, prev_data);
                    end
                end
                if (a_ovalid && !a_oready) begin
                    checks++;
                    if (a_iready !== 4'b0000) begin
                        errors++;
                        $display("FAIL stall_iready: got 0x%0h, required 0x0", a_iready);
                    end
                end
            end
            prev_stall = a_ovalid && !a_oready;
            prev_data  = a_odata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        sb_on    = 1'b1;
        reset    = 1'b1;
        a_oready = 1'b1;
        b_oready = 1'b1;
        b_idata  = '0;
        b_ivalid = '0;
        b_ilast  = '0;

        tbl[0] = '{src: 2, len: 3, base: 8'h11, exp_grant: 3'd2};
        tbl[1] = '{src: 0, len: 1, base: 8'h5A, exp_grant: 3'd0};
        tbl[2] = '{src: 3, len: 2, base: 8'h70, exp_grant: 3'd3};
        tbl[3] = '{src: 1, len: 4, base: 8'h08, exp_grant: 3'd1};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ovalid",  a_ovalid,  0);
        chk("rst_odata",   a_odata,   0);
        chk("rst_grant",   a_grant,   3);
        chk("rst_busy",    a_busy,    0);
        chk("rst_timeout", a_timeout, 0);
        chk("rst_iready",  a_iready,  0);
        chk("rst_grant_b", b_grant,   3);
        @(posedge clock);
        #2 reset = 1'b0;

        // ---------------- HEADER=0: source 0 then waiting source 1 ----------------
        b_idata  = {16'h0000, 8'h66, 8'h55};
        b_ivalid = 4'b0011;
        b_ilast  = 4'b0011;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (b_ovalid && b_oready) got.push_back(b_odata);
            if (b_busy && b_grant == 3'd0) chk("b_iready1_low", b_iready[1], 0);
            bacc = b_ivalid & b_iready;
            @(posedge clock);
            #1;
            b_ivalid = b_ivalid & ~bacc;
            b_ilast  = b_ilast & ~bacc;
        end
        chk("b_count", got.size(), 2);
        chk("b_byte0", (got.size() > 0) ? got[0] : 8'h00, 8'h55);
        chk("b_byte1", (got.size() > 1) ? got[1] : 8'h00, 8'h66);
        chk("b_timeout", b_timeout, 0);

        // ---------------- fairness: all four sources, two rounds ----------------
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                d = ((r == 0) ? 8'h40 : 8'h50) + 8'(k);
                sq[k].push_back({1'b1, d});
                exp_q.push_back({4'hA, 1'b0, 3'(k)});
                exp_q.push_back(d);
            end
        end
        wait_drain(120);
        chk("rr_grant", a_grant, 3);

        // ---------------- table-driven packets ----------------
        for (int t = 0; t < 4; t++) begin
            s = tbl[t].src;
            exp_q.push_back({4'hA, 1'b0, 3'(s)});
            for (int i = 0; i < tbl[t].len; i++) begin
                d = tbl[t].base + 8'(17 * i);
                sq[s].push_back({(i == tbl[t].len - 1), d});
                exp_q.push_back(d);
            end
            seen = 1'b0;
            for (int n = 0; n < 60 && !seen; n++) begin
                @(negedge clock);
                if (a_ivalid[s] && a_iready[s] && a_ilast[s]) seen = 1'b1;
            end
            chk("tbl_last_accept", seen, 1);
            @(negedge clock);
            chk("tbl_busy_drop", a_busy, 0);
            wait_drain(40);
            chk("tbl_grant", a_grant, tbl[t].exp_grant);
        end

        // ---------------- oready toggling during a 5-byte packet ----------------
        pat = 4'b1001;
        exp_q.push_back(8'hA1);
        for (int i = 0; i < 5; i++) begin
            d = 8'hC1 + 8'(i);
            sq[1].push_back({(i == 4), d});
            exp_q.push_back(d);
        end
        for (int c = 0; c < 80 && (exp_q.size() != 0 || a_busy); c++) begin
            @(posedge clock);
            #1 a_oready = pat[c % 4];
        end
        @(posedge clock);
        #1 a_oready = 1'b1;
        wait_drain(20);

        // ---------------- stall timeout ----------------
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'h99);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h3C);
        sq[1].push_back({1'b0, 8'h99});
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clock);
            if (a_ivalid[1] && a_iready[1]) seen = 1'b1;
        end
        chk("to_accept", seen, 1);
        sq[3].push_back({1'b1, 8'h3C});
        first  = -1;
        pulses = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (a_timeout) begin
                pulses++;
                if (first < 0) first = n;
            end
            if (n == 9) chk("to_idle", a_busy, 0);
        end
        chk("to_cycle", first, 9);
        chk("to_pulses", pulses, 1);
        wait_drain(40);
        chk("to_next_grant", a_grant, 3);

        // ---------------- reset in the middle of a packet ----------------
        sb_on = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) sq[2].push_back({(i == 4), 8'hE0 + 8'(i)});
        nacc = 0;
        for (int n = 0; n < 60 && nacc < 2; n++) begin
            @(negedge clock);
            if (a_ivalid[2] && a_iready[2]) nacc++;
        end
        chk("mr_accepts", nacc, 2);
        @(posedge clock);
        #2;
        chk("mr_pre_ovalid", a_ovalid, 1);
        reset = 1'b1;
        sq[2].delete();
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("mr_ovalid", a_ovalid, 0);
        chk("mr_busy",   a_busy,   0);
        chk("mr_iready", a_iready, 0);
        chk("mr_grant",  a_grant,  3);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'h2F);
        sb_on = 1'b1;
        sq[0].push_back({1'b1, 8'h0F});
        sq[2].push_back({1'b1, 8'h2F});
        wait_drain(60);
        chk("mr_final_grant", a_grant, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
